// File: rtl/pnl_bram_stream_reader.sv
// Drains a contiguous PNL BRAM region into a valid/ready stream with a last-word flag.
// Reads are issued only while the small output FIFO can absorb every word already in flight.
module pnl_bram_stream_reader #(
    parameter int unsigned PNL_BRAM_ADDR_SIZE_NB   = 15,
    parameter int unsigned PNL_BRAM_DBITS_WIDTH_NB = 16,
    parameter int unsigned FIFO_DEPTH              = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               ready,
    input  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   Num_Vals,
    input  logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   SRC_BRAM_addr,
    output logic [PNL_BRAM_ADDR_SIZE_NB-1:0]   PNL_BRAM_addr,
    input  logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] PNL_BRAM_dout,
    output logic                               PNL_BRAM_we,
    output logic                               out_valid,
    output logic [PNL_BRAM_DBITS_WIDTH_NB-1:0] out_data,
    output logic                               out_last,
    input  logic                               out_ready
);

    localparam int unsigned AW = PNL_BRAM_ADDR_SIZE_NB;
    localparam int unsigned DW = PNL_BRAM_DBITS_WIDTH_NB;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [AW:0] ONE_CNT = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_num;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_rd_cnt;
    logic [AW:0]   r_tx_cnt;
    logic          r_inflight;
    logic [DW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_issue;
    logic [AW-1:0] w_rd_addr;
    logic [AW:0]   w_last_idx;
    logic [OW-1:0] w_occ;
    logic [OW-1:0] w_lim;
    logic [CW-1:0] w_count_nxt;

    assign ready       = (r_state == S_IDLE);
    assign PNL_BRAM_we = 1'b0;
    assign out_valid   = (r_count != '0);
    assign out_data    = r_fifo[r_rptr];
    assign w_last_idx  = {1'b0, r_num} - ONE_CNT;
    assign out_last    = out_valid && (r_tx_cnt == w_last_idx);
    assign w_pop       = out_valid && out_ready;
    assign w_rd_addr   = r_base + r_rd_cnt[AW-1:0];

    // A pop this cycle frees a slot before the issued word lands, keeping full rate at depth 2.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_lim   = OW'(FIFO_DEPTH) + {{CW{1'b0}}, w_pop};
    assign w_issue = (r_state == S_STREAM) && (r_rd_cnt < {1'b0, r_num}) && (w_occ < w_lim);

    assign PNL_BRAM_addr = w_issue ? w_rd_addr : r_addr;

    always_comb begin
        w_count_nxt = r_count;
        if (r_inflight && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!r_inflight && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_base     <= '0;
            r_addr     <= '0;
            r_rd_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_inflight <= 1'b0;
                    if (start) begin
                        r_num    <= Num_Vals;
                        r_base   <= SRC_BRAM_addr;
                        r_rd_cnt <= '0;
                        r_tx_cnt <= '0;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_count  <= '0;
                        if (Num_Vals != '0) begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    r_inflight <= w_issue;
                    if (w_issue) begin
                        r_addr   <= w_rd_addr;
                        r_rd_cnt <= r_rd_cnt + ONE_CNT;
                    end
                    if (r_inflight) begin
                        r_fifo[r_wptr] <= PNL_BRAM_dout;
                        r_wptr         <= r_wptr + PW'(1);
                    end
                    if (w_pop) begin
                        r_rptr   <= r_rptr + PW'(1);
                        r_tx_cnt <= r_tx_cnt + ONE_CNT;
                        if (out_last) begin
                            r_state <= S_DONE;
                        end
                    end
                    r_count <= w_count_nxt;
                end
                default: begin
                    r_inflight <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pnl_bram_stream_reader.sv
// Scoreboard bench for pnl_bram_stream_reader: expected words are queued at launch,
// a negedge monitor pops and compares on every handshake.
module tb_pnl_bram_stream_reader;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic [14:0] Num_Vals;
    logic [14:0] SRC_BRAM_addr;
    logic [14:0] PNL_BRAM_addr;
    logic [15:0] PNL_BRAM_dout;
    logic        PNL_BRAM_we;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    pnl_bram_stream_reader #(
        .PNL_BRAM_ADDR_SIZE_NB  (15),
        .PNL_BRAM_DBITS_WIDTH_NB(16),
        .FIFO_DEPTH             (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .Num_Vals     (Num_Vals),
        .SRC_BRAM_addr(SRC_BRAM_addr),
        .PNL_BRAM_addr(PNL_BRAM_addr),
        .PNL_BRAM_dout(PNL_BRAM_dout),
        .PNL_BRAM_we  (PNL_BRAM_we),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [32768];
    always @(posedge clk) PNL_BRAM_dout <= mem[PNL_BRAM_addr];

    int          errors   = 0;
    int          checks   = 0;
    int          hs_count = 0;
    int          rdy_mode = 0;
    logic [16:0] exp_q[$];

    logic        mon_pv   = 1'b0;
    logic        mon_pr   = 1'b0;
    logic        mon_pl   = 1'b0;
    logic [15:0] mon_pd   = '0;
    logic        mon_prst = 1'b1;
    logic [16:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Consumer readiness: always, fixed 1,0,0 pattern, or random.
    initial begin
        int p;
        p = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (p % 3 == 0);
                    p++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_pv && !mon_pr && !mon_prst) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(mon_pd));
                chk("hold_last", 32'(out_last), 32'(mon_pl));
            end
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data 0x%0h last %0d, expected no word", out_data, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(mon_e[16:1]));
                    chk("word_last", 32'(out_last), 32'(mon_e[0]));
                end
                hs_count++;
            end
            mon_pv   = out_valid;
            mon_pr   = out_ready;
            mon_pd   = out_data;
            mon_pl   = out_last;
            mon_prst = reset;
        end
    end

    // Called in cycle 0; returns in cycle 1 with inputs scrambled to prove they were latched.
    task automatic launch(input logic [14:0] src, input logic [14:0] n);
        logic [14:0] a;
        chk("ready_before_start", 32'(ready), 32'd1);
        start         = 1'b1;
        SRC_BRAM_addr = src;
        Num_Vals      = n;
        for (int i = 0; i < int'(n); i++) begin
            a = src + 15'(i);
            exp_q.push_back({mem[a], (i == int'(n) - 1)});
        end
        next_cycle();
        start         = 1'b0;
        SRC_BRAM_addr = 15'($urandom);
        Num_Vals      = 15'($urandom);
    endtask

    task automatic wait_done(input int budget, input string name);
        int c;
        c = 0;
        while (!(exp_q.size() == 0 && ready === 1'b1) && c < budget) begin
            next_cycle();
            c++;
        end
        checks++;
        if (c >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words outstanding, expected 0 within %0d cycles", name, exp_q.size(), budget);
            exp_q.delete();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({name, "_quiet"}, 32'(out_valid), 32'd0);
            next_cycle();
        end
    endtask

    initial begin
        logic [14:0] off;
        int          hs0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);
        reset         = 1'b1;
        start         = 1'b0;
        Num_Vals      = '0;
        SRC_BRAM_addr = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_addr", 32'(PNL_BRAM_addr), 32'd0);
        chk("rst_we", 32'(PNL_BRAM_we), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Basic stream with exact cycle timing.
        launch(15'h0010, 15'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) chk("basic_addr0", 32'(PNL_BRAM_addr), 32'h0010);
            chk("basic_valid", 32'(out_valid), 32'(c >= 3 && c <= 6));
            chk("basic_last", 32'(out_last), 32'(c == 6));
            if (c >= 3 && c <= 6) chk("basic_data", 32'(out_data), 32'h1010 + 32'(c - 3));
            chk("basic_ready", 32'(ready), 32'(c == 8));
            chk("basic_we", 32'(PNL_BRAM_we), 32'd0);
            next_cycle();
        end
        wait_done(20, "basic");

        // Backpressure: reads never run more than DEPTH words ahead of the consumer.
        rdy_mode = 1;
        next_cycle();
        hs0 = hs_count;
        launch(15'h0010, 15'd4);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            off = PNL_BRAM_addr - 15'h0010;
            chk("bp_ahead", 32'(int'(off) - (hs_count - hs0) <= DEPTH), 32'd1);
            next_cycle();
        end
        wait_done(40, "bp");
        rdy_mode = 0;

        // Zero count.
        launch(15'h0040, 15'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("zero_ready", 32'(ready), 32'd1);
            chk("zero_valid", 32'(out_valid), 32'd0);
            next_cycle();
        end

        // Address wrap and single word.
        launch(15'h7FFE, 15'd3);
        wait_done(20, "wrap");
        launch(15'h1234, 15'd1);
        wait_done(20, "single");

        // Reset mid-transfer, then a fresh transfer.
        launch(15'h0100, 15'd10);
        repeat (4) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_last", 32'(out_last), 32'd0);
        exp_q.delete();
        next_cycle();
        launch(15'h0200, 15'd10);
        wait_done(40, "postrst");

        // Start while busy is ignored.
        launch(15'h0300, 15'd6);
        next_cycle();
        next_cycle();
        chk("ign_ready", 32'(ready), 32'd0);
        start         = 1'b1;
        SRC_BRAM_addr = 15'h0400;
        Num_Vals      = 15'd3;
        next_cycle();
        start = 1'b0;
        wait_done(40, "ignored");

        // Randomised transfers with random consumer stalls.
        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            next_cycle();
            launch(15'($urandom), 15'($urandom_range(1, 24)));
            wait_done(400, "rand");
        end
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
